clock_set_ctrl: RTL

Time-setting controller for the min1:min0:sec1:sec0 clock counter chain. Normally passes the run enable through to the counter. On a mode button it freezes the counter and captures the displayed time. It then steps through the four digit fields, each editable with an increment button, and commits the edited time back to the counter with a one-cycle load strobe. It also generates a per-digit blink/blank mask for the display driver.

---
 rtl/clock_pkg.sv | 24 ++
 rtl/clock_set_ctrl_blink_gen.sv | 29 ++
 rtl/clock_set_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared types and limits for the clock time-setting controller.
// Holds FSM state encoding, digit wrap limits and blank mask bit indices.
package clock_pkg;

   typedef enum logic [2:0] {
      ST_RUN     = 3'd0,
      ST_EDIT_M1 = 3'd1,
      ST_EDIT_M0 = 3'd2,
      ST_EDIT_S1 = 3'd3,
      ST_EDIT_S0 = 3'd4,
      ST_COMMIT  = 3'd5
   } state_t;

   localparam int unsigned MAX_SEC1  = 5;
   localparam int unsigned MAX_MIN1  = 5;
   localparam int unsigned MAX_UNITS = 9;

   // Bit positions in the {min1,min0,sec1,sec0} blank mask
   localparam int BLK_SEC0 = 0;
   localparam int BLK_SEC1 = 1;
   localparam int BLK_MIN0 = 2;
   localparam int BLK_MIN1 = 3;

endpackage

// File: rtl/clock_set_ctrl_blink_gen.sv
// Blink phase generator: counts 0..DIV-1 and toggles phase on wrap.
// Ports: clk, reset (sync high), clr (sync restart), phase out.
module blink_gen #(
   parameter int DIV = 25000000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic phase
);

   localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (cnt == LAST) begin
         cnt   <= '0;
         phase <= ~phase;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller for the min1:min0:sec1:sec0 counter chain.
// Ports: clk/reset, en, btn_mode/inc/cancel, cur_* in; run_en, load, ld_*, blank, editing out.
module clock_set_ctrl
   import clock_pkg::*;
#(
   parameter int DW        = 32,
   parameter int BLINK_DIV = 25000000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          btn_mode,
   input  logic          btn_inc,
   input  logic          btn_cancel,
   input  logic [DW-1:0] cur_sec0,
   input  logic [DW-1:0] cur_sec1,
   input  logic [DW-1:0] cur_min0,
   input  logic [DW-1:0] cur_min1,
   output logic          run_en,
   output logic          load,
   output logic [DW-1:0] ld_sec0,
   output logic [DW-1:0] ld_sec1,
   output logic [DW-1:0] ld_min0,
   output logic [DW-1:0] ld_min1,
   output logic [3:0]    blank,
   output logic          editing
);

   state_t        state;
   logic [DW-1:0] e_m1, e_m0, e_s1, e_s0;
   logic          phase;
   logic          blink_clr;

   // Values above the limit (bad capture) wrap straight to 0
   function automatic logic [DW-1:0] bump(
      input logic [DW-1:0] v,
      input int unsigned   mx
   );
      bump = (v >= DW'(mx)) ? '0 : v + DW'(1);
   endfunction

   // Restart blink so the edited field is visible on entry
   assign blink_clr = (state == ST_RUN) && btn_mode;

   blink_gen #(
      .DIV (BLINK_DIV)
   ) u_blink (
      .clk   (clk),
      .reset (reset),
      .clr   (blink_clr),
      .phase (phase)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_RUN;
         e_m1  <= '0;
         e_m0  <= '0;
         e_s1  <= '0;
         e_s0  <= '0;
      end else begin
         unique case (state)
            ST_RUN: begin
               if (btn_mode) begin
                  e_m1  <= cur_min1;
                  e_m0  <= cur_min0;
                  e_s1  <= cur_sec1;
                  e_s0  <= cur_sec0;
                  state <= ST_EDIT_M1;
               end
            end
            ST_EDIT_M1: begin
               if (btn_cancel)   state <= ST_RUN;
               else if (btn_mode) state <= ST_EDIT_M0;
               else if (btn_inc)  e_m1 <= bump(e_m1, MAX_MIN1);
            end
            ST_EDIT_M0: begin
               if (btn_cancel)   state <= ST_RUN;
               else if (btn_mode) state <= ST_EDIT_S1;
               else if (btn_inc)  e_m0 <= bump(e_m0, MAX_UNITS);
            end
            ST_EDIT_S1: begin
               if (btn_cancel)   state <= ST_RUN;
               else if (btn_mode) state <= ST_EDIT_S0;
               else if (btn_inc)  e_s1 <= bump(e_s1, MAX_SEC1);
            end
            ST_EDIT_S0: begin
               if (btn_cancel)   state <= ST_RUN;
               else if (btn_mode) state <= ST_COMMIT;
               else if (btn_inc)  e_s0 <= bump(e_s0, MAX_UNITS);
            end
            ST_COMMIT: state <= ST_RUN;
            default:   state <= ST_RUN;
         endcase
      end
   end

   assign run_en  = en & ~reset & (state == ST_RUN);
   assign load    = (state == ST_COMMIT);
   assign editing = (state == ST_EDIT_M1) || (state == ST_EDIT_M0) ||
                    (state == ST_EDIT_S1) || (state == ST_EDIT_S0);

   assign ld_min1 = e_m1;
   assign ld_min0 = e_m0;
   assign ld_sec1 = e_s1;
   assign ld_sec0 = e_s0;

   always_comb begin
      blank = 4'b0000;
      if (phase) begin
         unique case (state)
            ST_EDIT_M1: blank[BLK_MIN1] = 1'b1;
            ST_EDIT_M0: blank[BLK_MIN0] = 1'b1;
            ST_EDIT_S1: blank[BLK_SEC1] = 1'b1;
            ST_EDIT_S0: blank[BLK_SEC0] = 1'b1;
            default:    blank = 4'b0000;
         endcase
      end
   end

endmodule
